// File: rtl/if_fetch_if.sv
// Bundle of IF-stage signals: pipeline control and branch redirect in,
// fetch payload to ID and instruction SRAM request out.
interface if_fetch_if #(
    parameter int unsigned STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic [32:0]        br_bus;
    logic [32:0]        if_to_id_bus;
    logic               inst_sram_en;
    logic [3:0]         inst_sram_wen;
    logic [31:0]        inst_sram_addr;
    logic [31:0]        inst_sram_wdata;
    logic               if_adel;

    modport master (
        input  stall, br_bus,
        output if_to_id_bus, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata, if_adel
    );

    modport slave (
        output stall, br_bus,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen,
               inst_sram_addr, inst_sram_wdata, if_adel
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, SRAM read request and a one-entry
// buffer that keeps a branch redirect seen while the stage is stalled.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned STALL_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);
    localparam logic        STOP      = 1'b1;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] PC_RESET  = RESET_PC - PC_STEP;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} pend_e;

    pend_e       pend_st, pend_nx;
    logic [31:0] pc_r, pc_nx;
    logic        ce_r, ce_nx;
    logic [31:0] pend_addr, pend_addr_nx;

    logic        br_e;
    logic [31:0] br_addr;
    logic        stall_if;
    logic        stall_unused;

    assign br_e         = bus.br_bus[32];
    assign br_addr      = bus.br_bus[31:0];
    assign stall_if     = bus.stall[0];
    assign stall_unused = ^bus.stall[STALL_W-1:1];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r      <= PC_RESET;
            ce_r      <= 1'b0;
            pend_st   <= IDLE;
            pend_addr <= 32'd0;
        end else begin
            pc_r      <= pc_nx;
            ce_r      <= ce_nx;
            pend_st   <= pend_nx;
            pend_addr <= pend_addr_nx;
        end
    end

    // Next PC and redirect buffer; a live branch always beats a buffered one
    always_comb begin
        pc_nx        = pc_r;
        ce_nx        = ce_r;
        pend_nx      = pend_st;
        pend_addr_nx = pend_addr;
        if (stall_if != STOP) begin
            ce_nx   = 1'b1;
            pend_nx = IDLE;
            if (br_e) begin
                pc_nx = br_addr;
            end else if (pend_st == PEND) begin
                pc_nx = pend_addr;
            end else begin
                pc_nx = pc_r + PC_STEP;
            end
        end else if (br_e) begin
            pend_nx      = PEND;
            pend_addr_nx = br_addr;
        end
    end

    // Misaligned PCs are flagged and kept away from the SRAM
    assign bus.if_adel         = ce_r & (pc_r[1:0] != 2'b00);
    assign bus.if_to_id_bus    = {ce_r, pc_r};
    assign bus.inst_sram_en    = ce_r & ~bus.if_adel;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_r;
    assign bus.inst_sram_wdata = 32'd0;
endmodule
